// File: rtl/mul_pkg.sv
// mul_pkg
// Shared types and constants for the multiplier arbiter slice.
//   mul_op_e        : multiply flavour, passed through to the multiplier untouched
//   mul_arb_state_e : arbiter/sequencer FSM state encoding
//   MUL_XLEN        : default operand/result width
package mul_pkg;

    localparam int MUL_XLEN = 32;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,   // low 32 bits of signed x signed
        OP_MULH   = 2'b01,   // high 32 bits of signed x signed
        OP_MULHSU = 2'b10,   // high 32 bits of signed x unsigned
        OP_MULHU  = 2'b11    // high 32 bits of unsigned x unsigned
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mul_arb_state_e;

endpackage

// File: rtl/mul_arbiter_rr.sv
// rr_arbiter
// Combinational round-robin picker. The search starts one above last_grant
// and wraps, so the most recently served requester has lowest priority.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  ID_W     index of the previously granted requester
//   grant      out NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx  out ID_W     encoded grant index (0 when no request)
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic found;

    // Two ascending passes instead of a modular index: first the requesters
    // above last_grant, then the ones at or below it (the wrap-around).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[k] && (ID_W'(k) > last_grant)) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = ID_W'(k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[k] && (ID_W'(k) <= last_grant)) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter
// Shares one handshake multiplier between NUM_REQ requesters. One operation
// is in flight at a time: grant, issue operands, wait for the result strobe,
// present a tagged response, then return to arbitration.
// Optional feature macro: MUL_ARB_TIMEOUT_EN -- aborts an operation that
// spends TIMEOUT_CYCLES in ISSUE+WAIT, answering with result 0 and err 1.
// Ports:
//   clk, rst                   clock, async active-high reset
//   req_valid_i / req_ready_o  per-requester request handshake
//   req_a_i, req_b_i, req_op_i per-requester operands and op
//   rsp_valid_o / rsp_ready_i  shared response handshake
//   rsp_result_o, rsp_id_o     result and owning requester index
//   rsp_err_o                  response produced by timeout abort
//   mul_a_o, mul_b_o, mul_op_o latched operands to the multiplier
//   mul_in_valid_o / mul_in_ready_i    multiplier input handshake
//   mul_out_valid_i / mul_out_ready_o  multiplier result handshake
//   mul_result_i               multiplier result
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | arbitrating; req_ready_o shows the grant
// ST_ISSUE | operands presented, mul_in_valid_o high
// ST_WAIT  | mul_out_ready_o high, waiting for mul_out_valid_i
// ST_RESP  | rsp_valid_o high until rsp_ready_i
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int XLEN           = MUL_XLEN,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   req_a_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   req_b_i,
    input  logic [NUM_REQ-1:0][1:0]        req_op_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [XLEN-1:0]                rsp_result_o,
    output logic [ID_W-1:0]                rsp_id_o,
    output logic                           rsp_err_o,
    output logic [XLEN-1:0]                mul_a_o,
    output logic [XLEN-1:0]                mul_b_o,
    output logic [1:0]                     mul_op_o,
    output logic                           mul_in_valid_o,
    input  logic                           mul_in_ready_i,
    output logic                           mul_out_ready_o,
    input  logic                           mul_out_valid_i,
    input  logic [XLEN-1:0]                mul_result_i
);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mul_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    mul_arb_state_e     state;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               any_req;
    logic               timeout;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_valid_i),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign any_req = |req_valid_i;

    // Gated by rst so no accept is advertised while the block is held in reset.
    assign req_ready_o     = (state == ST_IDLE && !rst) ? grant : '0;
    assign mul_in_valid_o  = (state == ST_ISSUE);
    assign mul_out_ready_o = (state == ST_WAIT);
    assign rsp_valid_o     = (state == ST_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            last_grant   <= ID_W'(NUM_REQ - 1);
            mul_a_o      <= '0;
            mul_b_o      <= '0;
            mul_op_o     <= '0;
            rsp_id_o     <= '0;
            rsp_result_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        mul_a_o    <= req_a_i[grant_idx];
                        mul_b_o    <= req_b_i[grant_idx];
                        mul_op_o   <= req_op_i[grant_idx];
                        rsp_id_o   <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (timeout) begin
                        rsp_result_o <= '0;
                        state        <= ST_RESP;
                    end else if (mul_in_ready_i) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (timeout) begin
                        rsp_result_o <= '0;
                        state        <= ST_RESP;
                    end else if (mul_out_valid_i) begin
                        rsp_result_o <= mul_result_i;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Down-counter loaded at the grant edge; reaching zero while still in
    // ISSUE/WAIT means TIMEOUT_CYCLES cycles have been spent there.
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == ST_IDLE && any_req) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
        end else if ((state == ST_ISSUE || state == ST_WAIT) && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign timeout = (state == ST_ISSUE || state == ST_WAIT) && (tmo_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_o <= 1'b0;
        end else if (timeout) begin
            rsp_err_o <= 1'b1;
        end else if (state == ST_WAIT && mul_out_valid_i) begin
            rsp_err_o <= 1'b0;
        end
    end
`else
    assign timeout   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 32x32 handshake multiplier (MUL/MULH/MULHSU/MULHU) between NUM_REQ requesters, for example several issue ports or harts.
- Accepts one request at a time, latches its operands and drives the multiplier's input and output handshakes.
- Returns the result on a shared response channel tagged with the requester index.
- Sits between the execute-stage M-extension ports and the multiplier instance.

Parameters:
NUM_REQ, 2, number of requesters (at least 2).
XLEN, 32, operand and result width.
TIMEOUT_CYCLES, 64, cycles allowed in ISSUE+WAIT before abort (used only with the optional feature).

Ports:
clk  in  1  clock.
rst  in  1  reset.
req_valid_i  in  NUM_REQ  per-requester request valid.
req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high, and only in IDLE.
req_a_i  in  NUM_REQ x XLEN  operand a per requester.
req_b_i  in  NUM_REQ x XLEN  operand b per requester.
req_op_i  in  NUM_REQ x 2  mul_op_e per requester.
rsp_valid_o  out  1  response valid.
rsp_ready_i  in  1  response accept.
rsp_result_o  out  XLEN  result.
rsp_id_o  out  max(1,$clog2(NUM_REQ))  index of the owning requester.
rsp_err_o  out  1  response aborted by timeout.
mul_a_o / mul_b_o  out  XLEN  latched operands to the multiplier.
mul_op_o  out  2  latched op to the multiplier.
mul_in_valid_o  out  1  multiplier input valid.
mul_in_ready_i  in  1  multiplier input ready.
mul_out_ready_o  out  1  multiplier output ready.
mul_out_valid_i  in  1  multiplier result strobe (single-cycle pulse).
mul_result_i  in  XLEN  multiplier result.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - State is IDLE; all valid, ready and err outputs are 0.
  - rsp_result_o, rsp_id_o, mul_a_o, mul_b_o and mul_op_o are 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT, RESP. Exactly one transaction is in flight; there is no queueing.
- IDLE:
  - Grant g is the first requester with valid set, searching from (last_grant+1) mod NUM_REQ upward and wrapping.
  - req_ready_o[g] = 1 combinationally in the same cycle.
  - On that edge: latch a, b, op and the owner id; last_grant <= g; go to ISSUE.
  - With no valid requester, stay in IDLE.
- ISSUE: mul_in_valid_o = 1 with the latched operands held stable. When mul_in_ready_i = 1 is sampled, go to WAIT.
- WAIT:
  - mul_out_ready_o = 1.
  - When mul_out_valid_i = 1 is sampled: rsp_result_o <= mul_result_i, rsp_err_o <= 0, go to RESP.
- RESP:
  - rsp_valid_o = 1; result, id and err are held stable.
  - When rsp_ready_i = 1 is sampled, go to IDLE.
  - A new grant can occur no earlier than the cycle after the response handshake.
- Latency:
  - Accept to mul_in_valid_o: 1 cycle.
  - mul_out_valid_i to rsp_valid_o: 1 cycle.
  - Back-to-back throughput: one operation per (multiplier latency + 3) cycles.
- mul_out_valid_i outside WAIT is ignored. mul_in_valid_o and mul_out_ready_o are 0 outside ISSUE and WAIT respectively.
- Simultaneous requests are resolved by round-robin. A requester that keeps valid high is served again only after every other waiting requester has been served.
- Requester inputs are sampled only at the grant edge; later changes have no effect.
- Reset mid-operation: everything returns to reset values immediately and the in-flight operation is dropped. The multiplier is reset on the same net.
- op encoding: 00 MUL (low 32 bits), 01 MULH, 10 MULHSU, 11 MULHU. Passed through unchanged.

Optional Feature:
MUL_ARB_TIMEOUT_EN
- Defined:
  - A counter is cleared on entry to ISSUE and increments every cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to RESP with rsp_result_o = 0 and rsp_err_o = 1.
  - Any late mul_out_valid_i is ignored.
- Undefined: no counter; rsp_err_o is tied to 0; ISSUE and WAIT wait indefinitely.

Decomposition:
- Package mul_pkg:
  - mul_op_e enum (MUL, MULH, MULHSU, MULHU).
  - mul_arb_state_e enum (IDLE, ISSUE, WAIT, RESP).
  - MUL_XLEN = 32 constant.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and last_grant; outputs one-hot grant and encoded index. Purely combinational and reusable.

Test Plan:
- After reset, req0 only, a=7, b=6, op=MUL -> rsp_result_o=42, rsp_id_o=0, rsp_err_o=0; req_ready_o[0] pulses for exactly 1 cycle.
- req0 and req1 valid in the same cycle after reset, both op=MUL (3x5, 4x5) -> first response id=0 result=15, then id=1 result=20; next simultaneous pair is granted to 0 again.
- req1 a=0xFFFFFFFF, b=0xFFFFFFFF, op=MULHU -> rsp_result_o=0xFFFFFFFE, id=1. With op=MULH -> 0x00000000.
- rsp_ready_i held low for 5 cycles with req0 still valid -> rsp_valid_o, result and id stable; req_ready_o all 0; no mul_in_valid_o.
- rst pulsed high while in WAIT -> all outputs reset asynchronously. A following request a=2, b=3, op=MUL -> 6, id=0.
- With MUL_ARB_TIMEOUT_EN and a stub multiplier that never asserts mul_out_valid_i -> after 64 cycles, rsp_valid_o=1, rsp_err_o=1, rsp_result_o=0. A later stray mul_out_valid_i does not change the response.
